rr_priority_arbiter: RTL and testbench
======================================

// Module: rr_priority_arbiter
// PURPOSE
//  Registered N-way arbiter for shared resources such as output queues and the
//  SRAM port. Generalises the combinational priority encoder with four additions:
//   - any channel count;
//   - fixed or round-robin priority;
//   - a grant that is held until the winner releases it;
//   - an optional hold-time limit that forcibly revokes a grant.
//  Sits between per-port request logic and the shared resource mux.
// PARAMETERS
//  NUM_REQ                 8  number of requesters, >=2, any value (not just powers of 2)
//  IDX_WIDTH               3  width of grant_idx, must be >= clog2(NUM_REQ)
//  RIGHT_TO_LEFT_PRIORITY  1  1: higher index wins / RR searches downward; 0: lower index wins / RR searches upward
//  ROUND_ROBIN             1  0: fixed priority; 1: rotate priority after each grant
//  MAX_HOLD                0  max cycles a grant may be held; 0 = unlimited
// PORTS
//  clk          in   1          clock
//  reset_n      in   1          async reset, active low
//  req          in   NUM_REQ    request vector; bit k = requester k
//  release      in   1          pulse from the current grantee: transfer done
//  grant        out  NUM_REQ    one-hot grant, registered
//  grant_idx    out  IDX_WIDTH  binary index of grant; valid only when grant_vld=1
//  grant_vld    out  1          a grant is active
//  revoked      out  1          1-cycle pulse: grant removed by MAX_HOLD expiry
// BEHAVIOUR
//  Reset (async assert, sync deassert by the system):
//   - grant=0, grant_idx=0, grant_vld=0, revoked=0, hold counter=0.
//   - RR pointer: 0 when RIGHT_TO_LEFT_PRIORITY=1, NUM_REQ-1 otherwise, so the first RR search
//     matches fixed order.
//  FSM has 2 states:
//   - IDLE: if |req, a winner is selected combinationally and registered at the next edge.
//     grant/grant_idx/grant_vld go valid 1 cycle after req is seen. Go to GRANTED.
//   - GRANTED: outputs are held stable. Return to IDLE at the next edge, with grant_vld=0 in
//     the following cycle, on any one of:
//       a) release=1;
//       b) req[grant_idx]=0 (implicit release);
//       c) MAX_HOLD!=0 and the hold counter reaches MAX_HOLD-1. revoked=1 for exactly that one
//          cycle; a) or b) in the same cycle take precedence and suppress revoked.
//   - There is always >=1 idle cycle between grants.
//  Winner selection:
//   - Fixed mode: highest set index wins (RIGHT_TO_LEFT_PRIORITY=1), or lowest (=0).
//   - RR mode: search starts at ptr-1 and goes downward (RTL=1), or at ptr+1 and goes upward
//     (RTL=0), wrapping modulo NUM_REQ. ptr is loaded with the winner index on each grant.
//   - Requester bits >= NUM_REQ do not exist. Wrap arithmetic is modulo NUM_REQ, not 2**IDX_WIDTH.
//  Hold counter:
//   - Width clog2(MAX_HOLD+1); cleared on entering GRANTED and incremented each GRANTED cycle.
//   - Removed entirely when MAX_HOLD=0.
//  Boundaries:
//   - release asserted while in IDLE is ignored.
//   - A request arriving in the release cycle is arbitrated in the following IDLE cycle.
//   - Single requester: granted repeatedly, alternating with 1 idle cycle.
//   - reset_n low mid-grant: outputs clear immediately (async) and ptr returns to its reset value.
//  grant and grant_idx are always mutually consistent; grant=0 whenever grant_vld=0.
// TESTING (NUM_REQ=8 unless stated)
//  1 Reset: apply reset_n=0 with req=8'hFF -> grant=0, grant_vld=0, revoked=0 throughout reset.
//  2 Fixed, RTL=1: req=8'b0010_0101 -> next cycle grant=8'h20, grant_idx=5;
//    with RTL=0 -> grant=8'h01, grant_idx=0.
//  3 RR, RTL=1: req=8'hFF held, release pulsed each grant -> idx sequence 7,6,5,4,3,2,1,0,7,
//    with 1 idle cycle between grants.
//  4 Implicit release: grant to 3, then drop req[3] -> grant_vld=0 next cycle, revoked=0.
//  5 MAX_HOLD=4: req=8'h06 held, no release -> grant idx 2 for 4 cycles; revoked pulses on the
//    4th cycle; after the idle cycle, idx 1 is granted (RR).
//  6 NUM_REQ=5, RR, RTL=0: req=5'b10001, release each grant -> 0,4,0,4; grant_idx never >4;
//    async reset mid-grant -> outputs 0 within the same cycle.

Source files
------------

// File: rtl/rr_priority_arbiter_if.sv
// rr_priority_arbiter_if: request/grant bundle between requesters and the arbiter
interface rr_priority_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int IDX_WIDTH = 3
);
  logic [NUM_REQ-1:0] req;
  logic xfer_done;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic grant_vld;
  logic revoked;
  modport master (output req, xfer_done, input grant, grant_idx, grant_vld, revoked);
  modport slave (input req, xfer_done, output grant, grant_idx, grant_vld, revoked);
endinterface

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: registered N-way fixed/round-robin arbiter with held grants and optional hold limit
module rr_priority_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_WIDTH = 3,
  parameter int RIGHT_TO_LEFT_PRIORITY = 1,
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_HOLD = 0
) (
  input logic clk,
  input logic reset_n,
  rr_priority_arbiter_if.slave bus
);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [IDX_WIDTH-1:0] PTR_RST = RIGHT_TO_LEFT_PRIORITY != 0 ? '0 : IDX_WIDTH'(NUM_REQ - 1);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t state;
  logic [IDX_WIDTH-1:0] ptr, base, win;
  logic [HW-1:0] hold_cnt;
  logic expire, drop;
  // position i steps away from b in search direction, wrapping modulo NUM_REQ
  function automatic int pos(int b, int i);
    return RIGHT_TO_LEFT_PRIORITY != 0 ? (b + NUM_REQ - i) % NUM_REQ : (b + i) % NUM_REQ;
  endfunction
  // fixed priority is a round-robin search from a pointer frozen at its reset value
  assign base = ROUND_ROBIN != 0 ? ptr : PTR_RST;
  assign expire = MAX_HOLD != 0 && hold_cnt == HW'(MAX_HOLD - 1);
  assign drop = bus.xfer_done || !(|(bus.grant & bus.req));
  assign bus.grant_vld = state == GRANTED;
  assign bus.revoked = state == GRANTED && expire && !drop;
  // scan farthest-to-nearest so the requester closest to the pointer is assigned last and wins
  always_comb begin
    win = '0;
    for (int i = NUM_REQ; i >= 1; i--)
      if (bus.req[pos(int'(base), i)]) win = IDX_WIDTH'(pos(int'(base), i));
  end
  // grant FSM: register a winner from IDLE, hold it until release, implicit release or expiry
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.grant_idx <= '0;
      ptr <= PTR_RST;
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      if (|bus.req) begin
        state <= GRANTED;
        bus.grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
        bus.grant_idx <= win;
        ptr <= win;
        hold_cnt <= '0;
      end
    end else if (drop || expire) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.grant_idx <= '0;
    end else
      hold_cnt <= hold_cnt + HW'(1);
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb_rr_priority_arbiter: five arbiter configurations checked against a behavioural model
module tb_rr_priority_arbiter;
  localparam int NI = 5;
  localparam int NR [NI] = '{8, 8, 8, 8, 5};
  localparam int RR [NI] = '{1, 0, 0, 1, 1};
  localparam int R2L [NI] = '{1, 1, 0, 1, 0};
  localparam int MH [NI] = '{0, 0, 0, 4, 0};
  logic clk, reset_n;
  int checks = 0, errors = 0;
  int m_vld [NI], m_idx [NI], m_ptr [NI], m_cnt [NI];
  logic [7:0] o_grant [NI];
  logic [2:0] o_idx [NI];
  logic o_vld [NI], o_rev [NI];
  rr_priority_arbiter_if #(.NUM_REQ(8), .IDX_WIDTH(3)) if0 ();
  rr_priority_arbiter_if #(.NUM_REQ(8), .IDX_WIDTH(3)) if1 ();
  rr_priority_arbiter_if #(.NUM_REQ(8), .IDX_WIDTH(3)) if2 ();
  rr_priority_arbiter_if #(.NUM_REQ(8), .IDX_WIDTH(3)) if3 ();
  rr_priority_arbiter_if #(.NUM_REQ(5), .IDX_WIDTH(3)) if4 ();
  rr_priority_arbiter #(.NUM_REQ(8), .IDX_WIDTH(3), .RIGHT_TO_LEFT_PRIORITY(1), .ROUND_ROBIN(1), .MAX_HOLD(0))
    u0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  rr_priority_arbiter #(.NUM_REQ(8), .IDX_WIDTH(3), .RIGHT_TO_LEFT_PRIORITY(1), .ROUND_ROBIN(0), .MAX_HOLD(0))
    u1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  rr_priority_arbiter #(.NUM_REQ(8), .IDX_WIDTH(3), .RIGHT_TO_LEFT_PRIORITY(0), .ROUND_ROBIN(0), .MAX_HOLD(0))
    u2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));
  rr_priority_arbiter #(.NUM_REQ(8), .IDX_WIDTH(3), .RIGHT_TO_LEFT_PRIORITY(1), .ROUND_ROBIN(1), .MAX_HOLD(4))
    u3 (.clk(clk), .reset_n(reset_n), .bus(if3.slave));
  rr_priority_arbiter #(.NUM_REQ(5), .IDX_WIDTH(3), .RIGHT_TO_LEFT_PRIORITY(0), .ROUND_ROBIN(1), .MAX_HOLD(0))
    u4 (.clk(clk), .reset_n(reset_n), .bus(if4.slave));
  assign o_grant = '{if0.grant, if1.grant, if2.grant, if3.grant, {3'b0, if4.grant}};
  assign o_idx = '{if0.grant_idx, if1.grant_idx, if2.grant_idx, if3.grant_idx, if4.grant_idx};
  assign o_vld = '{if0.grant_vld, if1.grant_vld, if2.grant_vld, if3.grant_vld, if4.grant_vld};
  assign o_rev = '{if0.revoked, if1.revoked, if2.revoked, if3.revoked, if4.revoked};
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] live(int j, logic [7:0] r);
    int msk = (1 << NR[j]) - 1;
    return r & 8'(msk);
  endfunction
  function automatic int pick(int j, logic [7:0] rq);
    int n = NR[j];
    if (rq == 0) return -1;
    if (RR[j] == 0) begin
      if (R2L[j] != 0) begin
        for (int k = n - 1; k >= 0; k--) if (rq[k]) return k;
      end else begin
        for (int k = 0; k < n; k++) if (rq[k]) return k;
      end
      return -1;
    end
    for (int s = 1; s <= n; s++) begin
      int c = R2L[j] != 0 ? ((m_ptr[j] - s) % n + n) % n : (m_ptr[j] + s) % n;
      if (rq[c]) return c;
    end
    return -1;
  endfunction
  function automatic logic exp_rev(int j, logic [7:0] r, logic rl);
    logic [7:0] rq = live(j, r);
    return m_vld[j] != 0 && MH[j] != 0 && m_cnt[j] == MH[j] - 1 && !rl && rq[m_idx[j]];
  endfunction
  task automatic model_reset();
    for (int j = 0; j < NI; j++) begin
      m_vld[j] = 0;
      m_idx[j] = 0;
      m_cnt[j] = 0;
      m_ptr[j] = R2L[j] != 0 ? 0 : NR[j] - 1;
    end
  endtask
  task automatic model_step(input logic [7:0] r, input logic rl);
    for (int j = 0; j < NI; j++) begin
      logic [7:0] rq = live(j, r);
      if (m_vld[j] == 0) begin
        int w = pick(j, rq);
        if (w >= 0) begin
          m_vld[j] = 1;
          m_idx[j] = w;
          m_cnt[j] = 0;
          m_ptr[j] = w;
        end
      end else if (rl || !rq[m_idx[j]] || (MH[j] != 0 && m_cnt[j] == MH[j] - 1))
        m_vld[j] = 0;
      else
        m_cnt[j]++;
    end
  endtask
  task automatic drive(input logic [7:0] r, input logic rl);
    if0.req = r; if1.req = r; if2.req = r; if3.req = r; if4.req = r[4:0];
    if0.xfer_done = rl; if1.xfer_done = rl; if2.xfer_done = rl; if3.xfer_done = rl; if4.xfer_done = rl;
  endtask
  task automatic check_all_outputs();
    for (int j = 0; j < NI; j++) begin
      check($sformatf("vld%0d", j), 32'(o_vld[j]), 32'(m_vld[j] != 0));
      check($sformatf("grant%0d", j), 32'(o_grant[j]), m_vld[j] != 0 ? 32'(1) << m_idx[j] : 32'(0));
      if (m_vld[j] != 0) check($sformatf("idx%0d", j), 32'(o_idx[j]), 32'(m_idx[j]));
    end
  endtask
  task automatic cycle(input logic [7:0] r, input logic rl);
    drive(r, rl);
    #1;
    for (int j = 0; j < NI; j++) check($sformatf("rev%0d", j), 32'(o_rev[j]), 32'(exp_rev(j, r, rl)));
    @(posedge clk);
    model_step(r, rl);
    #1;
    check_all_outputs();
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset_n = 0;
    drive(8'hFF, 1'b0);
    model_reset();
    #1;
    check_all_outputs();
    for (int j = 0; j < NI; j++) check($sformatf("rst_rev%0d", j), 32'(o_rev[j]), 0);
    @(posedge clk);
    #1;
    check_all_outputs();
    @(negedge clk);
    reset_n = 1;
  endtask
  initial begin
    logic [7:0] r;
    reset_n = 0;
    drive(8'h00, 1'b0);
    @(negedge clk);
    do_reset();
    cycle(8'h25, 0);
    check("t2_fix_r2l_grant", 32'(if1.grant), 32'h20);
    check("t2_fix_r2l_idx", 32'(if1.grant_idx), 5);
    check("t2_fix_l2r_grant", 32'(if2.grant), 32'h01);
    check("t2_fix_l2r_idx", 32'(if2.grant_idx), 0);
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cycle(8'hFF, 0);
      check("t3_rr_idx", 32'(if0.grant_idx), 32'((15 - k) % 8));
      cycle(8'hFF, 1);
      check("t3_idle", 32'(if0.grant_vld), 0);
    end
    do_reset();
    cycle(8'h08, 0);
    check("t4_idx", 32'(if0.grant_idx), 3);
    cycle(8'h00, 0);
    check("t4_vld", 32'(if0.grant_vld), 0);
    check("t4_rev", 32'(if0.revoked), 0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(8'h06, 0);
      check("t5_idx", 32'(if3.grant_idx), 2);
      check("t5_rev", 32'(if3.revoked), 32'(k == 3));
    end
    cycle(8'h06, 0);
    check("t5_idle", 32'(if3.grant_vld), 0);
    cycle(8'h06, 0);
    check("t5_next_idx", 32'(if3.grant_idx), 1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(8'h11, 0);
      check("t6_idx", 32'(if4.grant_idx), k % 2 == 1 ? 4 : 0);
      cycle(8'h11, 1);
    end
    cycle(8'h11, 0);
    check("t6_pre_rst_idx", 32'(if4.grant_idx), 0);
    cycle(8'h11, 1);
    cycle(8'h11, 0);
    check("t6_pre_rst_idx2", 32'(if4.grant_idx), 4);
    #2 reset_n = 0;
    #1;
    check("t6_async_vld", 32'(if4.grant_vld), 0);
    check("t6_async_grant", 32'(if4.grant), 0);
    check("t6_async_idx", 32'(if4.grant_idx), 0);
    @(negedge clk);
    model_reset();
    reset_n = 1;
    cycle(8'h11, 0);
    check("t6_ptr_reset_idx", 32'(if4.grant_idx), 0);
    do_reset();
    r = 8'h00;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) r = 8'($urandom) & 8'($urandom | $urandom);
      cycle(r, $urandom_range(0, 4) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
